// File: rtl/pool_writer_pkg.sv
// Shared accelerator package: pool writer state encoding and default geometry.
package pool_writer_pkg;

  localparam int DEF_WORDS_PER_ROW = 4;
  localparam int DEF_OUT_ROWS      = 8;
  localparam int DEF_ADDR_W        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW_A = 2'd1,
    ROW_B = 2'd2,
    FIN   = 2'd3
  } pw_state_e;

endpackage

// File: rtl/pool_writer_byte_max4.sv
// Per-byte unsigned maximum of two packed 4x8-bit words; purely combinational.
module byte_max4 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  function automatic logic [7:0] umax8(input logic [7:0] x, input logic [7:0] z);
    return (x >= z) ? x : z;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_byte
    assign y[8*k +: 8] = umax8(a[8*k +: 8], b[8*k +: 8]);
  end

endmodule

// File: rtl/pool_writer.sv
// Vertical 2:1 max pooling writer: buffers row A, maxes it against row B and
// writes the pooled words to SRAM with a single registered write stage.
module pool_writer
  import pool_writer_pkg::*;
#(
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int OUT_ROWS      = DEF_OUT_ROWS,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic              convValid,
  input  logic [31:0]       convResult,
  output logic              memWen,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memData,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(OUT_ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WORDS_PER_ROW);

  pw_state_e         state, stateNext;
  logic [IDX_W-1:0]  wordIdx, curIdx;
  logic [ROW_W-1:0]  rowCnt;
  logic [ADDR_W-1:0] rowBase;
  logic [31:0]       lineBuf [WORDS_PER_ROW];

  logic              lastWord, lastRow;
  logic              startAcc, errSet;
  logic              accA_p0, vld_p0;
  logic [31:0]       bufWord_p0, maxWord_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    startAcc  = 1'b0;
    errSet    = 1'b0;
    accA_p0   = 1'b0;
    vld_p0    = 1'b0;
    // A word arriving together with start is word 0 of the new frame.
    curIdx    = (state == IDLE) ? '0 : wordIdx;
    lastWord  = (curIdx == LAST_IDX);
    lastRow   = (rowCnt == LAST_ROW);
    case (state)
      IDLE: begin
        if (start) begin
          startAcc  = 1'b1;
          stateNext = ROW_A;
          if (convValid) begin
            accA_p0 = 1'b1;
            if (lastWord) stateNext = ROW_B;
          end
        end else if (convValid) begin
          errSet = 1'b1;
        end
      end
      ROW_A: begin
        errSet = start;
        if (convValid) begin
          accA_p0 = 1'b1;
          if (lastWord) stateNext = ROW_B;
        end
      end
      ROW_B: begin
        errSet = start;
        if (convValid) begin
          vld_p0 = 1'b1;
          if (lastWord) stateNext = lastRow ? FIN : ROW_A;
        end
      end
      FIN: begin
        errSet    = start | convValid;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bufWord_p0 = lineBuf[curIdx];
  end

  byte_max4 u_max (
    .a (bufWord_p0),
    .b (convResult),
    .y (maxWord_p0)
  );

  // ---- p0 -> write stage: register SRAM command and frame bookkeeping ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wordIdx <= '0;
      rowCnt  <= '0;
      rowBase <= '0;
      for (int i = 0; i < WORDS_PER_ROW; i++) lineBuf[i] <= '0;
      memWen  <= 1'b0;
      memAddr <= '0;
      memData <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      memWen <= vld_p0;
      busy   <= (stateNext != IDLE);
      done   <= (state == FIN);

      if (startAcc)    err <= 1'b0;
      else if (errSet) err <= 1'b1;

      if (startAcc) begin
        rowBase <= baseAddr;
        rowCnt  <= '0;
        wordIdx <= '0;
      end

      if (accA_p0) begin
        lineBuf[curIdx] <= convResult;
        wordIdx         <= lastWord ? '0 : curIdx + IDX_W'(1);
      end

      if (vld_p0) begin
        memData <= maxWord_p0;
        memAddr <= rowBase + ADDR_W'(wordIdx);
        wordIdx <= lastWord ? '0 : wordIdx + IDX_W'(1);
        if (lastWord) begin
          rowCnt  <= rowCnt + ROW_W'(1);
          rowBase <= rowBase + ROW_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_writer.sv
// Directed bench for pool_writer: default geometry instance plus a single-row instance.
module tb_pool_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  baseAddr = '0;
  logic        convValid = 1'b0;
  logic [31:0] convResult = '0;

  logic        memWen, busy, done, err;
  logic [9:0]  memAddr;
  logic [31:0] memData;
  logic        memWen2, busy2, done2, err2;
  logic [9:0]  memAddr2;
  logic [31:0] memData2;

  int nChk = 0;
  int nPass = 0;
  int cyc = 0;

  logic [9:0]  wrA [64];
  logic [31:0] wrD [64];
  int          wrC [64];
  int          wrN = 0;
  logic [9:0]  wr2A [64];
  int          wr2N = 0;
  int          doneN = 0;
  int          doneC = 0;
  int          frameW0 = 0;

  pool_writer dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr),
    .convValid(convValid), .convResult(convResult),
    .memWen(memWen), .memAddr(memAddr), .memData(memData),
    .busy(busy), .done(done), .err(err)
  );

  pool_writer #(.WORDS_PER_ROW(4), .OUT_ROWS(1), .ADDR_W(10)) dut1row (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr),
    .convValid(convValid), .convResult(convResult),
    .memWen(memWen2), .memAddr(memAddr2), .memData(memData2),
    .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (memWen) begin
      if (wrN < 64) begin
        wrA[wrN] = memAddr;
        wrD[wrN] = memData;
        wrC[wrN] = cyc;
      end
      wrN++;
    end
    if (memWen2) begin
      if (wr2N < 64) wr2A[wr2N] = memAddr2;
      wr2N++;
    end
    if (done) begin
      doneN++;
      doneC = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Presents one word; acc returns the cycle index in which it was presented.
  task automatic feed(input logic [31:0] w, output int acc);
    acc        = cyc;
    convValid  = 1'b1;
    convResult = w;
    @(posedge clk); #1;
    convValid  = 1'b0;
  endtask

  task automatic pulse_start(input logic [9:0] b);
    start    = 1'b1;
    baseAddr = b;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    nChk++; if (memWen !== 1'b0)   $display("FAIL reset_memWen got=%0h exp=0", memWen);   else nPass++;
    nChk++; if (memAddr !== 10'h0) $display("FAIL reset_memAddr got=%0h exp=0", memAddr); else nPass++;
    nChk++; if (memData !== 32'h0) $display("FAIL reset_memData got=%0h exp=0", memData); else nPass++;
    nChk++; if (busy !== 1'b0)     $display("FAIL reset_busy got=%0h exp=0", busy);       else nPass++;
    nChk++; if (done !== 1'b0)     $display("FAIL reset_done got=%0h exp=0", done);       else nPass++;
    nChk++; if (err !== 1'b0)      $display("FAIL reset_err got=%0h exp=0", err);         else nPass++;
    rst = 1'b1;
    @(posedge clk); #1;
    nChk++; if (busy !== 1'b0)     $display("FAIL idle_busy got=%0h exp=0", busy);        else nPass++;
  endtask

  task automatic test_basic();
    int acc [4];
    int a;
    pulse_start(10'h010);
    nChk++; if (busy !== 1'b1) $display("FAIL basic_busy got=%0h exp=1", busy); else nPass++;
    nChk++; if (err !== 1'b0)  $display("FAIL basic_err got=%0h exp=0", err);   else nPass++;
    frameW0 = wrN;
    for (int i = 0; i < 4; i++) feed(32'h01020304, a);
    nChk++; if (memWen !== 1'b0) $display("FAIL basic_rowA_nowrite got=%0h exp=0", memWen); else nPass++;
    for (int i = 0; i < 4; i++) feed(32'h04030201, acc[i]);
    @(posedge clk); @(negedge clk); #1;
    nChk++; if (wrN - frameW0 !== 4) $display("FAIL basic_wrcount got=%0d exp=4", wrN - frameW0); else nPass++;
    for (int i = 0; i < 4; i++) begin
      nChk++; if (wrA[frameW0+i] !== 10'h010 + 10'(i))
        $display("FAIL basic_addr%0d got=%0h exp=%0h", i, wrA[frameW0+i], 10'h010 + 10'(i)); else nPass++;
      nChk++; if (wrD[frameW0+i] !== 32'h04030304)
        $display("FAIL basic_data%0d got=%0h exp=04030304", i, wrD[frameW0+i]); else nPass++;
      nChk++; if (wrC[frameW0+i] !== acc[i] + 1)
        $display("FAIL basic_lat%0d got=%0d exp=%0d", i, wrC[frameW0+i], acc[i] + 1); else nPass++;
    end
  endtask

  task automatic test_full_frame();
    int a = 0;
    for (int r = 1; r < 8; r++) begin
      for (int i = 0; i < 4; i++) feed(32'h80808080, a);
      for (int i = 0; i < 4; i++) feed(32'h7F817F81, a);
    end
    nChk++; if (memWen !== 1'b1)   $display("FAIL fin_memWen got=%0h exp=1", memWen);    else nPass++;
    nChk++; if (memAddr !== 10'h02F) $display("FAIL fin_memAddr got=%0h exp=02f", memAddr); else nPass++;
    nChk++; if (busy !== 1'b1)     $display("FAIL fin_busy got=%0h exp=1", busy);        else nPass++;
    nChk++; if (done !== 1'b0)     $display("FAIL fin_done got=%0h exp=0", done);        else nPass++;
    @(posedge clk); #1;
    nChk++; if (done !== 1'b1)     $display("FAIL done_pulse got=%0h exp=1", done);      else nPass++;
    nChk++; if (busy !== 1'b0)     $display("FAIL done_busy got=%0h exp=0", busy);       else nPass++;
    nChk++; if (memWen !== 1'b0)   $display("FAIL done_memWen got=%0h exp=0", memWen);   else nPass++;
    @(posedge clk); #1;
    nChk++; if (done !== 1'b0)     $display("FAIL done_single got=%0h exp=0", done);     else nPass++;
    @(negedge clk); #1;
    nChk++; if (wrN - frameW0 !== 32) $display("FAIL frame_wrcount got=%0d exp=32", wrN - frameW0); else nPass++;
    nChk++; if (wrA[frameW0+31] !== 10'h02F) $display("FAIL frame_lastaddr got=%0h exp=02f", wrA[frameW0+31]); else nPass++;
    for (int i = 4; i < 32; i++) begin
      nChk++; if (wrA[frameW0+i] !== 10'h010 + 10'(i) || wrD[frameW0+i] !== 32'h80818081)
        $display("FAIL frame_word%0d got=%0h/%0h exp=%0h/80818081", i, wrA[frameW0+i], wrD[frameW0+i], 10'h010 + 10'(i));
      else nPass++;
    end
    nChk++; if (doneN !== 1)     $display("FAIL done_count got=%0d exp=1", doneN);        else nPass++;
    nChk++; if (doneC !== a + 2) $display("FAIL done_cycle got=%0d exp=%0d", doneC, a + 2); else nPass++;
  endtask

  task automatic test_extremes();
    int a;
    int w0;
    pulse_start(10'h200);
    w0 = wrN;
    for (int i = 0; i < 4; i++) feed(32'hFF00FF00, a);
    for (int i = 0; i < 4; i++) feed(32'h00FF7F80, a);
    @(posedge clk); @(negedge clk); #1;
    nChk++; if (wrN - w0 !== 4) $display("FAIL ext_wrcount got=%0d exp=4", wrN - w0); else nPass++;
    for (int i = 0; i < 4; i++) begin
      nChk++; if (wrD[w0+i] !== 32'hFFFFFF80 || wrA[w0+i] !== 10'h200 + 10'(i))
        $display("FAIL ext_word%0d got=%0h/%0h exp=%0h/ffffff80", i, wrA[w0+i], wrD[w0+i], 10'h200 + 10'(i));
      else nPass++;
    end
  endtask

  task automatic test_reset_midframe();
    int a;
    int w0;
    for (int i = 0; i < 4; i++) feed(32'h00000000, a);
    feed(32'h00000001, a);
    feed(32'h00000002, a);
    rst = 1'b0;
    #1;
    nChk++; if (memWen !== 1'b0) $display("FAIL midrst_memWen got=%0h exp=0", memWen); else nPass++;
    nChk++; if (busy !== 1'b0)   $display("FAIL midrst_busy got=%0h exp=0", busy);     else nPass++;
    @(posedge clk); #1;
    rst = 1'b1;
    w0 = wrN;
    for (int i = 0; i < 4; i++) feed(32'h12345678, a);
    @(posedge clk); @(negedge clk); #1;
    nChk++; if (wrN !== w0)      $display("FAIL midrst_nowrite got=%0d exp=%0d", wrN, w0); else nPass++;
    nChk++; if (busy !== 1'b0)   $display("FAIL midrst_nostart got=%0h exp=0", busy);  else nPass++;
  endtask

  task automatic test_err();
    int a;
    int w0;
    do_reset();
    w0 = wrN;
    feed(32'hDEADBEEF, a);
    nChk++; if (err !== 1'b1)    $display("FAIL err_early_valid got=%0h exp=1", err);  else nPass++;
    nChk++; if (memWen !== 1'b0) $display("FAIL err_nowrite got=%0h exp=0", memWen);   else nPass++;
    @(posedge clk); #1;
    nChk++; if (err !== 1'b1)    $display("FAIL err_sticky got=%0h exp=1", err);       else nPass++;
    pulse_start(10'h000);
    nChk++; if (err !== 1'b0)    $display("FAIL err_cleared got=%0h exp=0", err);      else nPass++;
    pulse_start(10'h155);
    nChk++; if (err !== 1'b1)    $display("FAIL err_start_busy got=%0h exp=1", err);   else nPass++;
    nChk++; if (busy !== 1'b1)   $display("FAIL err_start_ignored got=%0h exp=1", busy); else nPass++;
    @(negedge clk); #1;
    nChk++; if (wrN !== w0)      $display("FAIL err_wrcount got=%0d exp=%0d", wrN, w0); else nPass++;
  endtask

  task automatic test_start_with_valid();
    int a;
    int w0;
    do_reset();
    w0 = wrN;
    start      = 1'b1;
    baseAddr   = 10'h100;
    convValid  = 1'b1;
    convResult = 32'h000000AA;
    @(posedge clk); #1;
    start      = 1'b0;
    convValid  = 1'b0;
    nChk++; if (err !== 1'b0) $display("FAIL swv_err got=%0h exp=0", err); else nPass++;
    feed(32'h0000BB00, a);
    feed(32'h00CC0000, a);
    feed(32'hDD000000, a);
    for (int i = 0; i < 4; i++) feed(32'h00000001, a);
    @(posedge clk); @(negedge clk); #1;
    nChk++; if (wrN - w0 !== 4) $display("FAIL swv_wrcount got=%0d exp=4", wrN - w0); else nPass++;
    nChk++; if (wrA[w0] !== 10'h100 || wrD[w0] !== 32'h000000AA)
      $display("FAIL swv_word0 got=%0h/%0h exp=100/000000aa", wrA[w0], wrD[w0]); else nPass++;
    nChk++; if (wrA[w0+1] !== 10'h101 || wrD[w0+1] !== 32'h0000BB01)
      $display("FAIL swv_word1 got=%0h/%0h exp=101/0000bb01", wrA[w0+1], wrD[w0+1]); else nPass++;
    nChk++; if (wrA[w0+3] !== 10'h103 || wrD[w0+3] !== 32'hDD000001)
      $display("FAIL swv_word3 got=%0h/%0h exp=103/dd000001", wrA[w0+3], wrD[w0+3]); else nPass++;
  endtask

  task automatic test_addr_wrap();
    int a;
    int w0;
    do_reset();
    w0 = wr2N;
    pulse_start(10'h3FE);
    for (int i = 0; i < 4; i++) feed(32'h11223344, a);
    for (int i = 0; i < 4; i++) feed(32'h11223344, a);
    nChk++; if (memWen2 !== 1'b1 || memAddr2 !== 10'h001)
      $display("FAIL wrap_last got=%0h/%0h exp=1/001", memWen2, memAddr2); else nPass++;
    nChk++; if (memData2 !== 32'h11223344) $display("FAIL wrap_tie got=%0h exp=11223344", memData2); else nPass++;
    @(posedge clk); #1;
    nChk++; if (done2 !== 1'b1 || busy2 !== 1'b0)
      $display("FAIL wrap_done got=%0h/%0h exp=1/0", done2, busy2); else nPass++;
    nChk++; if (busy !== 1'b1) $display("FAIL wrap_default_busy got=%0h exp=1", busy); else nPass++;
    @(negedge clk); #1;
    nChk++; if (wr2N - w0 !== 4) $display("FAIL wrap_wrcount got=%0d exp=4", wr2N - w0); else nPass++;
    nChk++; if (wr2A[w0] !== 10'h3FE) $display("FAIL wrap_addr0 got=%0h exp=3fe", wr2A[w0]);   else nPass++;
    nChk++; if (wr2A[w0+1] !== 10'h3FF) $display("FAIL wrap_addr1 got=%0h exp=3ff", wr2A[w0+1]); else nPass++;
    nChk++; if (wr2A[w0+2] !== 10'h000) $display("FAIL wrap_addr2 got=%0h exp=000", wr2A[w0+2]); else nPass++;
    nChk++; if (wr2A[w0+3] !== 10'h001) $display("FAIL wrap_addr3 got=%0h exp=001", wr2A[w0+3]); else nPass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_frame();
    test_extremes();
    test_reset_midframe();
    test_err();
    test_start_with_valid();
    test_addr_wrap();
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/pool_writer.md
POOL_WRITER -- requirements
Module: pool_writer

Interface
REQ-001 Parameter WORDS_PER_ROW, default 4, is the number of 32-bit horizontally pooled words per feature-map row.
REQ-002 Parameter OUT_ROWS, default 8, is the number of vertically pooled output rows per frame.
REQ-003 Parameter ADDR_W, default 10, is the output SRAM word-address width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame.
REQ-007 baseAddr  input  ADDR_W  output SRAM base address, latched on an accepted start.
REQ-008 convValid  input  1  upstream word valid, one word per cycle, no backpressure.
REQ-009 convResult  input  32  four unsigned 8-bit horizontally pooled pixels; byte k is bits [8k+7:8k].
REQ-010 memWen  output  1  SRAM write enable, active high.
REQ-011 memAddr  output  ADDR_W  SRAM write address.
REQ-012 memData  output  32  SRAM write data.
REQ-013 busy  output  1  high from an accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the last write of a frame.
REQ-015 err  output  1  sticky flag for a protocol violation.

Function
REQ-016 The FSM SHALL have the states IDLE, ROW_A, ROW_B and FIN.
REQ-017 In IDLE, start SHALL latch baseAddr, clear rowCnt and wordIdx, and enter ROW_A.
REQ-018 In ROW_A, each convValid SHALL store convResult into lineBuf[wordIdx] and increment wordIdx.
REQ-019 When wordIdx reaches WORDS_PER_ROW-1 in ROW_A, the FSM SHALL wrap wordIdx to 0 and enter ROW_B.
REQ-020 In ROW_B, each convValid SHALL compute a per-byte unsigned max of convResult and lineBuf[wordIdx].
REQ-021 In ROW_B, each convValid SHALL register memWen=1, memData=that max and memAddr=base+rowCnt*WORDS_PER_ROW+wordIdx (mod 2^ADDR_W).
REQ-022 The write latency SHALL be exactly 1 cycle: outputs are registered in the cycle after the accepted word.
REQ-023 memWen SHALL be low in every cycle without a ROW_B acceptance in the previous cycle.
REQ-024 At the end of a row in ROW_B, wordIdx SHALL wrap to 0 and rowCnt SHALL increment.
REQ-025 At the end of a row in ROW_B, the FSM SHALL enter ROW_A if rowCnt < OUT_ROWS-1; otherwise it SHALL enter FIN.
REQ-026 FIN SHALL last 1 cycle, in which the final memWen is visible; done SHALL pulse in the next cycle and the FSM SHALL return to IDLE.
REQ-027 busy SHALL be high in ROW_A, ROW_B and FIN.
REQ-028 start while busy SHALL be ignored and SHALL set err.
REQ-029 convValid in IDLE (without start) or in FIN SHALL be dropped and SHALL set err.
REQ-030 If start and convValid coincide in IDLE, the word SHALL be accepted as ROW_A word 0, using the new baseAddr.
REQ-031 err SHALL clear only on reset or on an accepted start.
REQ-032 Per-byte max SHALL be unsigned 8-bit; ties SHALL yield the equal value; no saturation is required.

Reset
REQ-033 When rst is low, the block SHALL immediately enter IDLE and clear rowCnt, wordIdx, base, lineBuf, memWen, memAddr, memData, busy, done and err to 0.
REQ-034 Reset mid-frame SHALL abandon the frame with no further writes; the first post-reset frame SHALL require a new start.

Structure
REQ-035 The state encoding and the default WORDS_PER_ROW, OUT_ROWS and ADDR_W values SHALL live in a shared accelerator package.
REQ-036 The per-byte max SHALL be a sub-module, byte_max4 (two 32-bit inputs, one 32-bit output, combinational), reusable by the horizontal pooling stage.

Verification
REQ-037 Defaults, base=0x010, row A words 0x01020304 x4, row B words 0x04030201 x4: expect 4 writes of 0x04030304 to addresses 0x010-0x013, each 1 cycle after its row B word.
REQ-038 A full frame of 8 row pairs: expect 32 writes ending at address base+31, done pulsing exactly once 2 cycles after the last word, and busy falling with done.
REQ-039 base=0x3FE and OUT_ROWS=1: expect writes to 0x3FE, 0x3FF, 0x000 and 0x001 (address wrap).
REQ-040 Byte extremes: row A 0xFF00FF00, row B 0x00FF7F80: expect data 0xFFFFFF80 (unsigned compare).
REQ-041 convValid before start: expect err=1 and no write; a following start clears err.
REQ-042 Assert rst low after 2 ROW_B words: expect memWen=0 and busy=0 immediately, and no writes until a new start.
